adc_sample_conditioner: RTL and testbench
=========================================

# adc_sample_conditioner

Sequences the on-chip sensor ADC and delivers conditioned 8-bit readings to the tag memory subsystem. It sits directly upstream of the memory/control wrapper: it selects the analog channel from the sensor code, settles, triggers conversions, averages `2^AVG_LOG2` raw samples and presents the result on `ADC_data` with a single-cycle `ADC_data_ready` strobe.

## Interface
Parameters:
- `RAW_W`, 10: raw ADC result width; must be ≥ 8.
- `AVG_LOG2`, 2: log2 of samples averaged per reading (0–4).
- `SETTLE_CYCLES`, 16: clk cycles waited after channel select before the first SOC.
- `TIMEOUT_CYCLES`, 255: maximum clk cycles waited for `adc_eoc` per conversion.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `sample_req` in 1: one-cycle request to take one reading.
- `senscode` in 3: one-hot-ish sensor select; the lowest set bit wins.
- `calibration_control` in 1: sampled at request; marks the reading as an offset calibration.
- `adc_raw` in RAW_W: raw conversion result, valid while `adc_eoc`=1.
- `adc_eoc` in 1: one-cycle end-of-conversion strobe.
- `adc_mux` out 2: analog channel select (0,1,2; 3 = park).
- `adc_soc` out 1: one-cycle start-of-conversion pulse.
- `ADC_data` out 8: conditioned reading, held until the next update.
- `ADC_data_ready` out 1: one-cycle strobe when `ADC_data` updates.
- `adc_error` out 1: one-cycle strobe on timeout.
- `busy` out 1: high in every state except IDLE.

## Operation
- Reset values: `adc_mux`=3, `adc_soc`=0, `ADC_data`=8'h00, `ADC_data_ready`=0, `adc_error`=0, `busy`=0. The accumulator, sample counter and offset register (when compiled in) are cleared.
- FSM states: IDLE, SETTLE, SOC, WAIT_EOC, ACCUM, DONE.
  - IDLE→SETTLE on `sample_req`=1 with `senscode`≠0. The block latches the channel (bit0→0, bit1→1, bit2→2) and `calibration_control`, and clears the accumulator and sample count.
  - In IDLE, `sample_req` with `senscode`=0 is ignored.
  - SETTLE lasts exactly SETTLE_CYCLES cycles, then goes to SOC.
  - SOC asserts `adc_soc` for one cycle, loads the timeout counter, and goes to WAIT_EOC.
  - WAIT_EOC→ACCUM on `adc_eoc`. If TIMEOUT_CYCLES cycles pass without EOC, the block pulses `adc_error`, sets `adc_mux`=3, returns to IDLE, and leaves `ADC_data` unchanged.
  - ACCUM adds `adc_raw` (captured at EOC) into the accumulator and increments the count. It goes to SOC if count < 2^AVG_LOG2, otherwise to DONE. No re-settle occurs between samples.
  - DONE computes the result, updates the output, pulses `ADC_data_ready`, sets `adc_mux`=3, and goes to IDLE.
- Arithmetic:
  - The accumulator is RAW_W+AVG_LOG2 bits, unsigned, and cannot overflow.
  - avg = acc >> AVG_LOG2, truncated.
  - `ADC_data` = avg[RAW_W-1:RAW_W-8] (top 8 bits).
- `sample_req` while `busy`=1 is ignored (not queued).
- `adc_eoc` outside WAIT_EOC is ignored.
- `senscode` and `calibration_control` changes after the request has been latched have no effect.
- `adc_mux` holds the latched channel from SETTLE through ACCUM.

## Timing
- Request→first `adc_soc`: SETTLE_CYCLES+1 cycles.
- Per sample: 1 (SOC) + EOC latency + 1 (ACCUM).
- Last EOC→`ADC_data_ready`: 2 cycles (ACCUM, DONE). `ADC_data` is valid in the same cycle as the strobe and is held afterwards.
- `busy` rises the cycle after the accepted request and falls the cycle after DONE or timeout.
- `reset` mid-operation: next cycle is IDLE with all outputs at reset values; a pending EOC is discarded.

## Configuration
- `ADC_OFFSET_CAL_EN` defined:
  - A reading requested with `calibration_control`=1 stores avg into an RAW_W-bit offset register. It still pulses `ADC_data_ready`, with `ADC_data`=8'h00.
  - Normal readings use avg_corr = (avg > offset) ? avg − offset : 0, then take the top 8 bits.
  - The offset register clears only on reset.
- `ADC_OFFSET_CAL_EN` undefined: no offset register; `calibration_control` is ignored and every reading is uncorrected.

## Test plan
- Defaults, `senscode`=3'b010, `sample_req` pulse, ADC model returns 10'h3FC four times, EOC 5 cycles after each SOC → `adc_mux`=1 during settle, first SOC 17 cycles after request, `ADC_data`=8'hFF with one `ADC_data_ready` pulse; `adc_mux`=3 afterwards.
- Samples 10'h100, 10'h104, 10'h108, 10'h10C → avg 10'h106, `ADC_data`=8'h41.
- No EOC after first SOC → `adc_error` pulse 256 cycles after SOC, no `ADC_data_ready`, `ADC_data` keeps its previous value, `busy`=0.
- `sample_req` repeated while busy, `senscode`=0 request, and stray `adc_eoc` in IDLE → no extra SOC, no state change; `senscode`=3'b110 selects channel 1.
- Reset asserted in WAIT_EOC, then an EOC arrives → outputs at reset values, no strobe; a fresh request completes normally.
- With `ADC_OFFSET_CAL_EN`: calibration reading at raw 10'h020, then a normal reading at raw 10'h120 → `ADC_data`=8'h40. A normal reading at raw 10'h010 → 8'h00.

Source files
------------

// File: rtl/adc_sample_conditioner_if.sv
// Sensor ADC conditioner bus: request side, ADC control/result side
// and the conditioned reading towards the tag memory wrapper.
interface adc_sample_conditioner_if #(
  parameter int RAW_W = 10
);
  logic             sample_req;
  logic [2:0]       senscode;
  logic             calibration_control;
  logic [RAW_W-1:0] adc_raw;
  logic             adc_eoc;
  logic [1:0]       adc_mux;
  logic             adc_soc;
  logic [7:0]       ADC_data;
  logic             ADC_data_ready;
  logic             adc_error;
  logic             busy;

  modport master (
    input  sample_req, senscode, calibration_control,
    input  adc_raw, adc_eoc,
    output adc_mux, adc_soc, ADC_data, ADC_data_ready,
    output adc_error, busy
  );

  modport slave (
    output sample_req, senscode, calibration_control,
    output adc_raw, adc_eoc,
    input  adc_mux, adc_soc, ADC_data, ADC_data_ready,
    input  adc_error, busy
  );
endinterface

// File: rtl/adc_sample_conditioner.sv
// Sequences the sensor ADC and averages 2^AVG_LOG2 raw samples per reading.
// Define ADC_OFFSET_CAL_EN to compile in the offset calibration register.
module adc_sample_conditioner #(
  parameter int RAW_W          = 10,
  parameter int AVG_LOG2       = 2,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  adc_sample_conditioner_if.master  bus
);

  localparam int ACC_W   = RAW_W + AVG_LOG2;
  localparam int CNT_W   = AVG_LOG2 + 1;
  localparam int TMR_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ?
                           SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX + 1);
  localparam logic [CNT_W-1:0] N_SAMP = CNT_W'(1 << AVG_LOG2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SOC,
    S_WAIT_EOC,
    S_ACCUM,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       chan_q, chan_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [RAW_W-1:0] raw_q, raw_d;
  logic [7:0]       data_q, data_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic [1:0]       sel_chan;
  logic [ACC_W-1:0] acc_sum;
  logic [RAW_W-1:0] avg;
`ifdef ADC_OFFSET_CAL_EN
  logic             cal_q, cal_d;
  logic [RAW_W-1:0] off_q, off_d;
  logic [RAW_W-1:0] avg_corr;
`else
  logic             unused_cal;
  assign unused_cal = bus.calibration_control;
`endif

  assign acc_sum = acc_q + ACC_W'(raw_q);
  assign avg     = acc_sum[ACC_W-1:AVG_LOG2];

  // lowest set senscode bit picks the channel
  always_comb begin
    sel_chan = 2'd0;
    priority case (1'b1)
      bus.senscode[0]: sel_chan = 2'd0;
      bus.senscode[1]: sel_chan = 2'd1;
      bus.senscode[2]: sel_chan = 2'd2;
      default:         sel_chan = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    raw_d   = raw_q;
    data_d  = data_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
`ifdef ADC_OFFSET_CAL_EN
    cal_d    = cal_q;
    off_d    = off_q;
    avg_corr = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.sample_req && (bus.senscode != 3'b000)) begin
          state_d = S_SETTLE;
          chan_d  = sel_chan;
          acc_d   = '0;
          cnt_d   = '0;
          tmr_d   = TMR_W'(SETTLE_CYCLES - 1);
`ifdef ADC_OFFSET_CAL_EN
          cal_d   = bus.calibration_control;
`endif
        end
      end
      S_SETTLE: begin
        if (tmr_q == '0) state_d = S_SOC;
        else             tmr_d   = tmr_q - 1'b1;
      end
      S_SOC: begin
        tmr_d   = TMR_W'(TIMEOUT_CYCLES - 1);
        state_d = S_WAIT_EOC;
      end
      S_WAIT_EOC: begin
        if (bus.adc_eoc) begin
          raw_d   = bus.adc_raw;
          state_d = S_ACCUM;
        end else if (tmr_q == '0) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmr_d   = tmr_q - 1'b1;
        end
      end
      S_ACCUM: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 1'b1;
        if (cnt_d == N_SAMP) begin
          // result lands in the output register as DONE begins
          state_d = S_DONE;
          ready_d = 1'b1;
`ifdef ADC_OFFSET_CAL_EN
          if (cal_q) begin
            off_d  = avg;
            data_d = 8'h00;
          end else begin
            avg_corr = (avg > off_q) ? (avg - off_q) : '0;
            data_d   = avg_corr[RAW_W-1 -: 8];
          end
`else
          data_d  = avg[RAW_W-1 -: 8];
`endif
        end else begin
          state_d = S_SOC;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      chan_q  <= 2'd0;
      acc_q   <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      raw_q   <= '0;
      data_q  <= 8'h00;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef ADC_OFFSET_CAL_EN
      cal_q   <= 1'b0;
      off_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      raw_q   <= raw_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      err_q   <= err_d;
`ifdef ADC_OFFSET_CAL_EN
      cal_q   <= cal_d;
      off_q   <= off_d;
`endif
    end
  end

  assign bus.adc_soc        = (state_q == S_SOC);
  assign bus.busy           = (state_q != S_IDLE);
  assign bus.adc_mux        = (state_q inside {S_SETTLE, S_SOC,
                              S_WAIT_EOC, S_ACCUM}) ? chan_q : 2'd3;
  assign bus.ADC_data       = data_q;
  assign bus.ADC_data_ready = ready_q;
  assign bus.adc_error      = err_q;

endmodule

// File: tb/tb_adc_sample_conditioner.sv
// Randomized self-checking bench for adc_sample_conditioner.
// The bench plays the ADC; a plain-arithmetic model predicts each reading.
module tb_adc_sample_conditioner;

  localparam int RAW_W  = 10;
  localparam int AVG_L2 = 2;
  localparam int N      = 4;
  localparam int SETTLE = 16;
  localparam int TMO    = 255;

  logic clk;
  logic reset;

  adc_sample_conditioner_if #(.RAW_W(RAW_W)) bus ();

  adc_sample_conditioner #(
    .RAW_W(RAW_W),
    .AVG_LOG2(AVG_L2),
    .SETTLE_CYCLES(SETTLE),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [RAW_W-1:0] raw_vals [N];
  logic [7:0]       m_data;
  logic [RAW_W-1:0] m_off;

  int         o_first_soc, o_soc_n, o_ready_n, o_ready_cyc;
  int         o_err_n, o_err_cyc, o_mux_bad, o_busy_bad, o_hung;
  logic [7:0] o_data, o_data_end;
  logic [1:0] o_mux_end;
  logic       o_busy_end;

  // reading = mean of samples (truncated), optionally minus offset, top 8 bits
  function automatic logic [7:0] model_reading(input logic cal);
    int sum, avg, corr;
    sum = 0;
    for (int i = 0; i < N; i++) sum += int'(raw_vals[i]);
    avg = sum / N;
`ifdef ADC_OFFSET_CAL_EN
    if (cal) begin
      m_off = RAW_W'(avg);
      return 8'h00;
    end
    corr = (avg > int'(m_off)) ? avg - int'(m_off) : 0;
`else
    corr = cal ? avg : avg;
`endif
    return 8'(corr >> (RAW_W - 8));
  endfunction

  // one request; the bench answers n_ans SOCs with EOC lat cycles later
  task automatic run_reading(input logic [2:0] sc, input logic cal,
                             input int lat, input int n_ans,
                             input bit spam);
    int eoc_due, answered, term, chan;
    chan = sc[0] ? 0 : (sc[1] ? 1 : 2);
    o_first_soc = -1; o_soc_n = 0; o_ready_n = 0; o_ready_cyc = -1;
    o_err_n = 0; o_err_cyc = -1; o_mux_bad = 0; o_busy_bad = 0;
    o_hung = 0; o_data = 8'h00;
    eoc_due = -1; answered = 0; term = -1;
    @(negedge clk);
    bus.sample_req = 1'b1;
    bus.senscode = sc;
    bus.calibration_control = cal;
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk);
      if (term < 0) begin
        if (bus.ADC_data_ready === 1'b1 || bus.adc_error === 1'b1) begin
          term = c;
          if (bus.adc_mux !== 2'd3) o_mux_bad++;
        end else begin
          if (bus.adc_mux !== 2'(chan)) o_mux_bad++;
          if (bus.busy !== 1'b1) o_busy_bad++;
        end
      end
      if (bus.adc_soc === 1'b1) begin
        o_soc_n++;
        if (o_first_soc < 0) o_first_soc = c;
        if (answered < n_ans) eoc_due = c + lat;
      end
      if (bus.ADC_data_ready === 1'b1) begin
        o_ready_n++;
        o_ready_cyc = c;
        o_data = bus.ADC_data;
      end
      if (bus.adc_error === 1'b1) begin
        o_err_n++;
        o_err_cyc = c;
      end
      if (spam && term < 0) begin
        bus.sample_req = 1'($urandom_range(0, 1));
        bus.senscode = 3'($urandom);
        bus.calibration_control = 1'($urandom_range(0, 1));
      end else begin
        bus.sample_req = 1'b0;
      end
      bus.adc_eoc = (c == eoc_due);
      if (c == eoc_due) begin
        bus.adc_raw = (answered < N) ? raw_vals[answered] : '0;
        answered++;
      end else begin
        bus.adc_raw = RAW_W'($urandom);
      end
      if (term >= 0 && c == term + 3) begin
        o_mux_end = bus.adc_mux;
        o_busy_end = bus.busy;
        o_data_end = bus.ADC_data;
        return;
      end
    end
    o_hung = 1;
    bus.sample_req = 1'b0;
    bus.adc_eoc = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.sample_req = 1'b0;
    bus.senscode = 3'b000;
    bus.calibration_control = 1'b0;
    bus.adc_raw = '0;
    bus.adc_eoc = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.adc_mux, bus.adc_soc, bus.ADC_data_ready,
         bus.adc_error, bus.busy} !== 6'b11_0000) begin
      n_bad++;
      $display("FAIL reset_ctrl: got mux=%0d soc=%b rdy=%b err=%b busy=%b want 3 0 0 0 0",
               bus.adc_mux, bus.adc_soc, bus.ADC_data_ready,
               bus.adc_error, bus.busy);
    end
    n_cmp++;
    if (bus.ADC_data !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_data: got %h want 00", bus.ADC_data);
    end
    m_data = 8'h00;
    m_off = '0;
  endtask

  task automatic test_plan_full_scale();
    for (int i = 0; i < N; i++) raw_vals[i] = 10'h3FC;
    m_data = model_reading(1'b0);
    run_reading(3'b010, 1'b0, 5, N, 1'b0);
    n_cmp++;
    if (o_hung !== 0) begin
      n_bad++; $display("FAIL fs_hung: got %0d want 0", o_hung);
    end
    n_cmp++;
    if (o_first_soc !== SETTLE + 1) begin
      n_bad++;
      $display("FAIL fs_first_soc: got %0d want %0d", o_first_soc, SETTLE + 1);
    end
    n_cmp++;
    if (o_mux_bad !== 0 || o_busy_bad !== 0) begin
      n_bad++;
      $display("FAIL fs_mux_busy: got %0d/%0d bad cycles want 0/0", o_mux_bad, o_busy_bad);
    end
    n_cmp++;
    if (o_data !== 8'hFF || o_ready_n !== 1) begin
      n_bad++;
      $display("FAIL fs_data: got %h x%0d want ff x1", o_data, o_ready_n);
    end
    n_cmp++;
    if (o_ready_cyc !== SETTLE + 1 + N * 7) begin
      n_bad++;
      $display("FAIL fs_ready_cyc: got %0d want %0d", o_ready_cyc, SETTLE + 1 + N * 7);
    end
    n_cmp++;
    if (o_mux_end !== 2'd3 || o_busy_end !== 1'b0 || o_soc_n !== N) begin
      n_bad++;
      $display("FAIL fs_after: got mux=%0d busy=%b socs=%0d want 3 0 %0d",
               o_mux_end, o_busy_end, o_soc_n, N);
    end
  endtask

  task automatic test_plan_average();
    raw_vals[0] = 10'h100; raw_vals[1] = 10'h104;
    raw_vals[2] = 10'h108; raw_vals[3] = 10'h10C;
    m_data = model_reading(1'b0);
    run_reading(3'b001, 1'b0, 2, N, 1'b0);
    n_cmp++;
    if (o_data !== 8'h41 || o_ready_n !== 1 || o_hung !== 0) begin
      n_bad++;
      $display("FAIL avg_data: got %h x%0d hung=%0d want 41 x1 0", o_data, o_ready_n, o_hung);
    end
  endtask

  task automatic test_random();
    logic [2:0] sc;
    int lat;
    for (int k = 0; k < 6; k++) begin
      do sc = 3'($urandom); while (sc == 3'b000);
      lat = $urandom_range(1, 9);
      for (int i = 0; i < N; i++) raw_vals[i] = RAW_W'($urandom);
      m_data = model_reading(1'b0);
      run_reading(sc, 1'b0, lat, N, 1'b0);
      n_cmp++;
      if (o_data !== m_data || o_ready_n !== 1) begin
        n_bad++;
        $display("FAIL rnd%0d_data: got %h x%0d want %h x1", k, o_data, o_ready_n, m_data);
      end
      n_cmp++;
      if (o_ready_cyc !== SETTLE + 1 + N * (lat + 2) || o_soc_n !== N) begin
        n_bad++;
        $display("FAIL rnd%0d_timing: got rdy@%0d socs=%0d want rdy@%0d socs=%0d",
                 k, o_ready_cyc, o_soc_n, SETTLE + 1 + N * (lat + 2), N);
      end
      n_cmp++;
      if (o_mux_bad !== 0 || o_busy_bad !== 0 || o_data_end !== m_data) begin
        n_bad++;
        $display("FAIL rnd%0d_mux_hold: got %0d/%0d bad, held %h want 0/0 %h",
                 k, o_mux_bad, o_busy_bad, o_data_end, m_data);
      end
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < N; i++) raw_vals[i] = RAW_W'($urandom);
    run_reading(3'b100, 1'b0, 3, 0, 1'b0);
    n_cmp++;
    if (o_err_n !== 1 || o_err_cyc !== SETTLE + 1 + TMO + 1) begin
      n_bad++;
      $display("FAIL tmo_err: got x%0d @%0d want x1 @%0d", o_err_n, o_err_cyc, SETTLE + TMO + 2);
    end
    n_cmp++;
    if (o_ready_n !== 0 || o_data_end !== m_data) begin
      n_bad++;
      $display("FAIL tmo_data: got rdy x%0d data %h want x0 %h", o_ready_n, o_data_end, m_data);
    end
    n_cmp++;
    if (o_busy_end !== 1'b0 || o_mux_end !== 2'd3 || o_mux_bad !== 0) begin
      n_bad++;
      $display("FAIL tmo_idle: got busy=%b mux=%0d bad=%0d want 0 3 0",
               o_busy_end, o_mux_end, o_mux_bad);
    end
    // answer two samples then stall: still a timeout
    run_reading(3'b001, 1'b0, 4, 2, 1'b0);
    n_cmp++;
    if (o_err_n !== 1 || o_ready_n !== 0 || o_err_cyc !== SETTLE + 1 + 2 * 6 + TMO + 1) begin
      n_bad++;
      $display("FAIL tmo_mid: got err x%0d @%0d rdy x%0d want x1 @%0d x0",
               o_err_n, o_err_cyc, o_ready_n, SETTLE + 2 * 6 + TMO + 2);
    end
  endtask

  task automatic test_ignored();
    int act;
    act = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (bus.adc_soc !== 1'b0 || bus.busy !== 1'b0 ||
          bus.ADC_data_ready !== 1'b0 || bus.adc_mux !== 2'd3) act++;
      bus.sample_req = 1'($urandom_range(0, 1));
      bus.senscode = 3'b000;
      bus.calibration_control = 1'($urandom_range(0, 1));
      bus.adc_eoc = 1'($urandom_range(0, 1));
      bus.adc_raw = RAW_W'($urandom);
    end
    bus.sample_req = 1'b0;
    bus.adc_eoc = 1'b0;
    n_cmp++;
    if (act !== 0) begin
      n_bad++; $display("FAIL idle_ignore: got %0d active cycles want 0", act);
    end
    for (int i = 0; i < N; i++) raw_vals[i] = RAW_W'($urandom);
    m_data = model_reading(1'b0);
    run_reading(3'b110, 1'b0, 3, N, 1'b1);
    n_cmp++;
    if (o_mux_bad !== 0 || o_soc_n !== N || o_ready_n !== 1) begin
      n_bad++;
      $display("FAIL busy_spam: got mux_bad=%0d socs=%0d rdy=%0d want 0 %0d 1",
               o_mux_bad, o_soc_n, o_ready_n, N);
    end
    n_cmp++;
    if (o_data !== m_data) begin
      n_bad++; $display("FAIL busy_spam_data: got %h want %h", o_data, m_data);
    end
  endtask

  task automatic test_calibration();
`ifdef ADC_OFFSET_CAL_EN
    for (int i = 0; i < N; i++) raw_vals[i] = 10'h020;
    m_data = model_reading(1'b1);
    run_reading(3'b001, 1'b1, 2, N, 1'b0);
    n_cmp++;
    if (o_data !== 8'h00 || o_ready_n !== 1) begin
      n_bad++; $display("FAIL cal_store: got %h x%0d want 00 x1", o_data, o_ready_n);
    end
    for (int i = 0; i < N; i++) raw_vals[i] = 10'h120;
    m_data = model_reading(1'b0);
    run_reading(3'b001, 1'b0, 2, N, 1'b0);
    n_cmp++;
    if (o_data !== 8'h40) begin
      n_bad++; $display("FAIL cal_corr: got %h want 40", o_data);
    end
    for (int i = 0; i < N; i++) raw_vals[i] = 10'h010;
    m_data = model_reading(1'b0);
    run_reading(3'b010, 1'b0, 2, N, 1'b0);
    n_cmp++;
    if (o_data !== 8'h00) begin
      n_bad++; $display("FAIL cal_floor: got %h want 00", o_data);
    end
`else
    for (int i = 0; i < N; i++) raw_vals[i] = 10'h120;
    m_data = model_reading(1'b1);
    run_reading(3'b001, 1'b1, 2, N, 1'b0);
    n_cmp++;
    if (o_data !== 8'h48 || o_ready_n !== 1) begin
      n_bad++; $display("FAIL cal_ignored: got %h x%0d want 48 x1", o_data, o_ready_n);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int s, act;
    s = -1;
    act = 0;
    @(negedge clk);
    bus.sample_req = 1'b1;
    bus.senscode = 3'b001;
    bus.calibration_control = 1'b0;
    for (int c = 1; c < 100 && s < 0; c++) begin
      @(negedge clk);
      bus.sample_req = 1'b0;
      if (bus.adc_soc === 1'b1) s = c;
    end
    n_cmp++;
    if (s < 0) begin
      n_bad++; $display("FAIL rstmid_soc: got no SOC want one within 100 cycles");
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    bus.adc_eoc = 1'b1;
    bus.adc_raw = 10'h3FF;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if ({bus.adc_mux, bus.adc_soc, bus.ADC_data_ready, bus.adc_error,
         bus.busy, bus.ADC_data} !== {2'd3, 4'b0000, 8'h00}) begin
      n_bad++;
      $display("FAIL rstmid_outputs: got mux=%0d soc=%b rdy=%b err=%b busy=%b data=%h want 3 0 0 0 0 00",
               bus.adc_mux, bus.adc_soc, bus.ADC_data_ready, bus.adc_error,
               bus.busy, bus.ADC_data);
    end
    m_data = 8'h00;
    m_off = '0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      bus.adc_eoc = 1'b0;
      if (bus.adc_soc !== 1'b0 || bus.busy !== 1'b0 ||
          bus.ADC_data_ready !== 1'b0 || bus.adc_error !== 1'b0) act++;
    end
    n_cmp++;
    if (act !== 0) begin
      n_bad++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", act);
    end
    for (int i = 0; i < N; i++) raw_vals[i] = RAW_W'($urandom);
    m_data = model_reading(1'b0);
    run_reading(3'b100, 1'b0, 4, N, 1'b0);
    n_cmp++;
    if (o_data !== m_data || o_ready_n !== 1 || o_mux_bad !== 0) begin
      n_bad++;
      $display("FAIL rstmid_fresh: got %h x%0d mux_bad=%0d want %h x1 0",
               o_data, o_ready_n, o_mux_bad, m_data);
    end
  endtask

  initial begin
    test_reset();
    test_plan_full_scale();
    test_plan_average();
    test_random();
    test_timeout();
    test_ignored();
    test_calibration();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
